msg_fifo: RTL and testbench
===========================

// Module: msg_fifo
// PURPOSE
//  Per-source message buffer feeding one slot of the packet encoder's source buses.
//  Accepts a byte stream with end-of-message marks and stores bytes plus per-message lengths.
//  Presents only complete messages as have_msg/len/data, with show-ahead data popped by rdreq.
//  N_SRC instances are concatenated into have_msg_bus/len_bus/data_bus/rdreq_bus.
// PARAMETERS
//  DEPTH      256  data byte storage, power of 2, >= 256
//  MSG_DEPTH  8    max complete messages queued, power of 2
// PORTS
//  clk        in   1                  single clock, all logic on posedge
//  n_rst      in   1                  async active-low reset
//  wr_data    in   8                  byte to store
//  wr_valid   in   1                  wr_data valid
//  wr_last    in   1                  byte is the final byte of its message
//  wr_ready   out  1                  byte accepted when wr_valid & wr_ready
//  have_msg   out  1                  >=1 complete message queued
//  len        out  8                  byte count of head message, 1..255; 0 when !have_msg
//  data       out  8                  show-ahead head byte; 0 when !have_msg
//  rdreq      in   1                  pop one byte of head message
//  msg_count  out  $clog2(MSG_DEPTH)+1  complete messages queued
//  overflow   out  1                  sticky drop flag (MSG_FIFO_DROP_EN only, else tied 0)
// BEHAVIOUR
//  Reset: all pointers, counters and outputs 0; wr_ready 0 during reset, 1 from first clock after.
//  Reset mid-message: partial and queued messages are discarded, nothing replayed.
//  Write side:
//   - wr_cnt counts bytes of open message; message start pointer held for commit/rewind.
//   - Commit on accepted byte with wr_last=1, or automatically at 255th byte (wr_cnt=255).
//   - Commit pushes length to length FIFO; next byte starts a new message at wr_cnt=0.
//   - wr_ready = !(data storage full) & !(length FIFO full).
//  Read side:
//   - have_msg, len, msg_count update the cycle after commit (1-cycle latency).
//   - data = byte at rd pointer whenever have_msg; after rdreq, next byte on data next cycle.
//   - rd_cnt counts popped bytes; rdreq with rd_cnt+1 == len pops length FIFO, rd_cnt <= 0.
//   - rdreq while !have_msg ignored (no pointer movement).
//   - Uncommitted bytes never visible on read side, even if rd pointer would reach them.
//  Simultaneous commit and final pop: msg_count unchanged, have_msg stays 1, len switches
//   to next head length next cycle.
//  Pointers wrap modulo DEPTH / MSG_DEPTH; full/empty tracked with extra MSB bit.
//  Free space counted against committed read pointer (bytes of head message freed as popped).
// CONFIGURATION
//  MSG_FIFO_DROP_EN defined:
//   - wr_ready tied 1 after reset; writes never back-pressure the producer.
//   - Byte arriving with no room: write pointer rewound to message start, wr_cnt <= 0,
//     remaining bytes of that message discarded up to and including wr_last; overflow <= 1.
//   - overflow sticky until reset; already committed messages unaffected.
//  MSG_FIFO_DROP_EN undefined: back-pressure via wr_ready as above; overflow tied 0.
// TESTING
//  1. Write 3 bytes 0x11,0x22,0x33 (last on 0x33) -> have_msg=1 next cycle, len=3, data=0x11;
//     3 rdreq pulses -> data 0x22, 0x33, then have_msg=0, len=0, msg_count=0.
//  2. Write 300 bytes with no wr_last -> commit after byte 255 (len=255), second message
//     of 45 bytes committed on wr_last; msg_count=2.
//  3. Fill MSG_DEPTH=8 one-byte messages -> wr_ready=0, 9th write stalls; pop one message
//     -> wr_ready=1 next cycle, 9th commits.
//  4. Final rdreq of message A in same cycle as wr_last of message B -> msg_count stays 1,
//     len=B length, data=B first byte next cycle.
//  5. Assert n_rst low mid-write (wr_cnt=5) and with 2 messages queued -> all outputs 0;
//     after release have_msg=0, wr_ready=1.
//  6. DROP_EN: DEPTH=256 full of committed data, write 4-byte message -> none stored,
//     overflow=1, msg_count unchanged; pop all, rewrite -> accepted, overflow stays 1.

Source files
------------

// File: rtl/msg_fifo.sv
// Per-source message buffer: stores a byte stream plus per-message lengths
// and presents only complete messages as show-ahead have_msg/len/data.
// Optional build macro MSG_FIFO_DROP_EN: never back-pressure the producer;
// a message that does not fit is dropped in full and the sticky overflow flag is set.
module msg_fifo #(
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned MSG_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic [7:0]                   wr_data,
    input  logic                         wr_valid,
    input  logic                         wr_last,
    output logic                         wr_ready,
    output logic                         have_msg,
    output logic [7:0]                   len,
    output logic [7:0]                   data,
    input  logic                         rdreq,
    output logic [$clog2(MSG_DEPTH):0]   msg_count,
    output logic                         overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned MW = $clog2(MSG_DEPTH);

    logic [7:0] mem_q     [DEPTH];
    logic [7:0] len_mem_q [MSG_DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d, start_q, start_d, rd_ptr_q, rd_ptr_d;
    logic [MW:0] lwr_q, lwr_d, lrd_q, lrd_d;
    logic [7:0]  wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic        wr_ready_q, wr_ready_d, have_q, have_d;
    logic [7:0]  len_q, len_d, data_q, data_d;
    logic [MW:0] cnt_q, cnt_d;

    logic        wr_en, commit, pop, pop_msg;
    logic [7:0]  commit_len;
    logic        data_full, len_full;
    logic [MW:0] lused_n;

`ifdef MSG_FIFO_DROP_EN
    logic        ovf_q, ovf_d, drop_q, drop_d;
`endif

    // Next-state logic for pointers, counters and registered outputs
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        start_d    = start_q;
        rd_ptr_d   = rd_ptr_q;
        lwr_d      = lwr_q;
        lrd_d      = lrd_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        wr_en      = 1'b0;
        commit     = 1'b0;
        commit_len = wr_cnt_q + 8'd1;
`ifdef MSG_FIFO_DROP_EN
        ovf_d      = ovf_q;
        drop_d     = drop_q;
`endif

        data_full = (wr_ptr_q - rd_ptr_q) == (AW+1)'(DEPTH);
        len_full  = (lwr_q - lrd_q) == (MW+1)'(MSG_DEPTH);

        // Read side: pop one byte of the head message
        pop     = rdreq & have_q;
        pop_msg = pop & ((rd_cnt_q + 8'd1) == len_q);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            rd_cnt_d = pop_msg ? 8'd0 : rd_cnt_q + 8'd1;
            if (pop_msg) begin
                lrd_d = lrd_q + (MW+1)'(1);
            end
        end

        // Write side: accept, or in drop mode rewind and discard the whole message
`ifdef MSG_FIFO_DROP_EN
        if (wr_valid && wr_ready_q) begin
            if (drop_q) begin
                if (wr_last) begin
                    drop_d = 1'b0;
                end
            end else if (data_full || len_full) begin
                wr_ptr_d = start_q;
                wr_cnt_d = 8'd0;
                ovf_d    = 1'b1;
                drop_d   = !wr_last;
            end else begin
                wr_en = 1'b1;
            end
        end
`else
        wr_en = wr_valid & wr_ready_q;
`endif

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (wr_last || (wr_cnt_q == 8'd254)) begin
                commit   = 1'b1;
                wr_cnt_d = 8'd0;
                start_d  = wr_ptr_q + (AW+1)'(1);
                lwr_d    = lwr_q + (MW+1)'(1);
            end else begin
                wr_cnt_d = wr_cnt_q + 8'd1;
            end
        end

        // Registered outputs are derived from the next state
        lused_n = lwr_d - lrd_d;
        cnt_d   = lused_n;
        have_d  = (lwr_d != lrd_d);
`ifdef MSG_FIFO_DROP_EN
        wr_ready_d = 1'b1;
`else
        wr_ready_d = ((wr_ptr_d - rd_ptr_d) != (AW+1)'(DEPTH)) &&
                     (lused_n != (MW+1)'(MSG_DEPTH));
`endif
        len_d  = 8'd0;
        data_d = 8'd0;
        if (have_d) begin
            // Head entry may be the length or byte being written this very cycle
            len_d  = (commit && (lrd_d == lwr_q)) ? commit_len : len_mem_q[lrd_d[MW-1:0]];
            data_d = (wr_en && (rd_ptr_d == wr_ptr_q)) ? wr_data : mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    // State registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q   <= '0;
            start_q    <= '0;
            rd_ptr_q   <= '0;
            lwr_q      <= '0;
            lrd_q      <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wr_ready_q <= 1'b0;
            have_q     <= 1'b0;
            len_q      <= '0;
            data_q     <= '0;
            cnt_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            start_q    <= start_d;
            rd_ptr_q   <= rd_ptr_d;
            lwr_q      <= lwr_d;
            lrd_q      <= lrd_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_ready_q <= wr_ready_d;
            have_q     <= have_d;
            len_q      <= len_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef MSG_FIFO_DROP_EN
    // Sticky overflow flag and discard-until-last state
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf_q  <= 1'b0;
            drop_q <= 1'b0;
        end else begin
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end
    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    // Byte and length storage (no reset needed; contents gated by pointers)
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
        if (commit) begin
            len_mem_q[lwr_q[MW-1:0]] <= commit_len;
        end
    end

    assign wr_ready  = wr_ready_q;
    assign have_msg  = have_q;
    assign len       = len_q;
    assign data      = data_q;
    assign msg_count = cnt_q;

endmodule

// File: tb/tb_msg_fifo.sv
// Directed self-checking bench for msg_fifo (DEPTH=256, MSG_DEPTH=8).
module tb_msg_fifo;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       wr_last;
    logic       wr_ready;
    logic       have_msg;
    logic [7:0] len;
    logic [7:0] data;
    logic       rdreq;
    logic [3:0] msg_count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

`ifdef MSG_FIFO_DROP_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    msg_fifo #(.DEPTH(256), .MSG_DEPTH(8)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_last  (wr_last),
        .wr_ready (wr_ready),
        .have_msg (have_msg),
        .len      (len),
        .data     (data),
        .rdreq    (rdreq),
        .msg_count(msg_count),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one byte and hold it until accepted (bounded)
    task automatic wr_byte(input logic [7:0] b, input logic last);
        logic accepted;
        accepted = 1'b0;
        wr_data  = b;
        wr_last  = last;
        wr_valid = 1'b1;
        for (int t = 0; t < 50 && !accepted; t++) begin
            accepted = wr_ready;
            tick();
        end
        chk("wr_accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic wr_idle();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_data  = 8'h00;
    endtask

    task automatic pop_n(input int n);
        rdreq = 1'b1;
        for (int k = 0; k < n; k++) tick();
        rdreq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst = 1'b0;
        wr_idle();
        rdreq = 1'b0;
        tick();
        tick();
        chk("rst_wr_ready", 32'(wr_ready), 0);
        chk("rst_have", 32'(have_msg), 0);
        chk("rst_len", 32'(len), 0);
        chk("rst_data", 32'(data), 0);
        chk("rst_count", 32'(msg_count), 0);
        chk("rst_ovf", 32'(overflow), 0);
        n_rst = 1'b1;
        tick();
        chk("post_rst_wr_ready", 32'(wr_ready), 1);

        // 1: three-byte message, show-ahead reads
        wr_byte(8'h11, 1'b0);
        wr_byte(8'h22, 1'b0);
        chk("t1_uncommitted_hidden", 32'(have_msg), 0);
        wr_byte(8'h33, 1'b1);
        wr_idle();
        chk("t1_have", 32'(have_msg), 1);
        chk("t1_len", 32'(len), 3);
        chk("t1_data0", 32'(data), 32'h11);
        chk("t1_count", 32'(msg_count), 1);
        rdreq = 1'b1;
        tick();
        chk("t1_data1", 32'(data), 32'h22);
        tick();
        chk("t1_data2", 32'(data), 32'h33);
        tick();
        rdreq = 1'b0;
        chk("t1_have_end", 32'(have_msg), 0);
        chk("t1_len_end", 32'(len), 0);
        chk("t1_count_end", 32'(msg_count), 0);
        chk("t1_data_end", 32'(data), 0);
        rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
        chk("t1_idle_rdreq_ignored", 32'(have_msg), 0);

        // 2: 300 bytes without wr_last -> 255 auto-commit + 45
        for (int i = 0; i < 255; i++) wr_byte(8'(i), 1'b0);
        wr_idle();
        chk("t2_len255", 32'(len), 255);
        chk("t2_count1", 32'(msg_count), 1);
        chk("t2_data0", 32'(data), 0);
        rdreq = 1'b1;
        for (int i = 255; i < 300; i++) wr_byte(8'(i), i == 299);
        rdreq = 1'b0;
        wr_idle();
        chk("t2_count2", 32'(msg_count), 2);
        chk("t2_head_len", 32'(len), 255);
        chk("t2_data45", 32'(data), 45);
        pop_n(210);
        chk("t2_count_after_a", 32'(msg_count), 1);
        chk("t2_len45", 32'(len), 45);
        chk("t2_data_b0", 32'(data), 32'hFF);
        pop_n(45);
        chk("t2_drained", 32'(have_msg), 0);

`ifndef MSG_FIFO_DROP_EN
        // 3: eight one-byte messages fill the length FIFO
        wr_byte(8'hA0, 1'b1);
        chk("t3_bypass_data", 32'(data), 32'hA0);
        for (int k = 1; k < 8; k++) wr_byte(8'(8'hA0 + k), 1'b1);
        chk("t3_full_ready", 32'(wr_ready), 0);
        chk("t3_count8", 32'(msg_count), 8);
        wr_data  = 8'hA8;
        wr_last  = 1'b1;
        wr_valid = 1'b1;
        tick();
        tick();
        chk("t3_stall_count", 32'(msg_count), 8);
        rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
        chk("t3_ready_after_pop", 32'(wr_ready), 1);
        chk("t3_count7", 32'(msg_count), 7);
        chk("t3_data_next", 32'(data), 32'hA1);
        tick();
        wr_idle();
        chk("t3_ninth_commit", 32'(msg_count), 8);
        pop_n(8);
        chk("t3_drained", 32'(msg_count), 0);
`endif

        // 4: final pop of A coincides with wr_last of B
        wr_byte(8'h51, 1'b0);
        wr_byte(8'h52, 1'b1);
        wr_idle();
        pop_n(1);
        chk("t4_a_data1", 32'(data), 32'h52);
        wr_byte(8'h61, 1'b0);
        rdreq = 1'b1;
        wr_byte(8'h62, 1'b1);
        rdreq = 1'b0;
        wr_idle();
        chk("t4_count", 32'(msg_count), 1);
        chk("t4_have", 32'(have_msg), 1);
        chk("t4_len", 32'(len), 2);
        chk("t4_data", 32'(data), 32'h61);
        pop_n(2);
        chk("t4_drained", 32'(have_msg), 0);

        // 5: reset mid-message with two messages queued
        wr_byte(8'h71, 1'b1);
        wr_byte(8'h72, 1'b1);
        for (int k = 0; k < 5; k++) wr_byte(8'(8'h80 + k), 1'b0);
        chk("t5_pre_count", 32'(msg_count), 2);
        n_rst = 1'b0;
        #2;
        chk("t5_rst_have", 32'(have_msg), 0);
        chk("t5_rst_ready", 32'(wr_ready), 0);
        chk("t5_rst_len", 32'(len), 0);
        chk("t5_rst_count", 32'(msg_count), 0);
        wr_idle();
        tick();
        n_rst = 1'b1;
        tick();
        chk("t5_have", 32'(have_msg), 0);
        chk("t5_ready", 32'(wr_ready), 1);
        wr_byte(8'h99, 1'b1);
        wr_idle();
        chk("t5_no_replay_len", 32'(len), 1);
        chk("t5_no_replay_data", 32'(data), 32'h99);
        pop_n(1);

        // 6: data storage completely full of committed bytes
        for (int i = 0; i < 255; i++) wr_byte(8'(i), 1'b0);
        wr_byte(8'hEE, 1'b1);
        wr_idle();
        chk("t6_count_full", 32'(msg_count), 2);
`ifdef MSG_FIFO_DROP_EN
        chk("t6_ready_tied", 32'(wr_ready), 1);
        for (int k = 0; k < 4; k++) wr_byte(8'(8'hB0 + k), k == 3);
        wr_idle();
        chk("t6_drop_count", 32'(msg_count), 2);
        chk("t6_ovf_set", 32'(overflow), 1);
        chk("t6_head_intact", 32'(len), 255);
`else
        chk("t6_full_ready", 32'(wr_ready), 0);
        chk("t6_ovf_tied", 32'(overflow), 0);
`endif
        pop_n(256);
        chk("t6_empty", 32'(msg_count), 0);
        chk("t6_ready_empty", 32'(wr_ready), 1);
        for (int k = 0; k < 4; k++) wr_byte(8'(8'hC0 + k), k == 3);
        wr_idle();
        chk("t6_rewrite_count", 32'(msg_count), 1);
        chk("t6_rewrite_len", 32'(len), 4);
        chk("t6_rewrite_data", 32'(data), 32'hC0);
        chk("t6_ovf_sticky", 32'(overflow), 32'(EXP_OVF));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
